pon_burst_scheduler: RTL and testbench

- Sequences the upstream PON burst transmitter: repeating frame of preamble, payload, then idle gap, driven by the run-time preamble/burst/period lengths and the enable bit from the debug VIO.
- Sits between the VIO configuration outputs and the GT TX datapath: gates the laser/tx enable, selects preamble vs payload, and requests payload words from the upstream FIFO.
- All logic runs in the TX user clock domain; no CDC inside the block.

---
 rtl/pon_sched_pkg.sv | 27 ++
 rtl/pon_cfg_shadow.sv | 48 ++++
 rtl/pon_burst_scheduler.sv | 140 ++++++++++++++
 tb/tb_pon_burst_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pon_sched_pkg.sv
// Shared definitions for the PON upstream burst scheduler.
//   - Default counter widths for length/period inputs and the frame counter.
//   - Scheduler state enum plus fixed encodings for ILA probe decoding.
//   - is_tx(): true for states that drive the laser (PRE and DATA).
package pon_sched_pkg;

  localparam int unsigned CntWDefault  = 32;
  localparam int unsigned BcntWDefault = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPre  = 2'd1,
    StData = 2'd2,
    StGap  = 2'd3
  } sched_state_e;

  // Raw encodings so ILA captures can be decoded without the enum.
  localparam logic [1:0] StIdleEnc = 2'd0;
  localparam logic [1:0] StPreEnc  = 2'd1;
  localparam logic [1:0] StDataEnc = 2'd2;
  localparam logic [1:0] StGapEnc  = 2'd3;

  function automatic logic is_tx(sched_state_e s);
    return (s == StPre) || (s == StData);
  endfunction

endpackage

// File: rtl/pon_cfg_shadow.sv
// Frame configuration shadow for the burst scheduler.
// Captures preamble/burst/period lengths on a load strobe (frame launch) so that
// mid-frame changes on the live inputs only take effect at the next launch.
// Also flags whether the live inputs form a launchable configuration.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   load              capture p_in/b_in/t_in this cycle
//   p_in, b_in, t_in  live preamble, payload and period lengths
//   p, b, t           shadowed lengths for the running frame
//   cfg_ok            live inputs valid: T!=0, P+B!=0, P+B<=T
module pon_cfg_shadow
  import pon_sched_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] p_in,
  input  logic [CNT_W-1:0] b_in,
  input  logic [CNT_W-1:0] t_in,
  output logic [CNT_W-1:0] p,
  output logic [CNT_W-1:0] b,
  output logic [CNT_W-1:0] t,
  output logic             cfg_ok
);

  // One extra bit so P+B can never wrap.
  logic [CNT_W:0] sum;

  always_comb begin
    sum    = {1'b0, p_in} + {1'b0, b_in};
    cfg_ok = (t_in != '0) && (sum != '0) && (sum <= {1'b0, t_in});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
      b <= '0;
      t <= '0;
    end else if (load) begin
      p <= p_in;
      b <= b_in;
      t <= t_in;
    end
  end

endmodule

// File: rtl/pon_burst_scheduler.sv
// Upstream PON burst scheduler: repeating frame of P preamble cycles, B payload
// cycles and an idle gap, with a frame period of T cycles. All outputs registered.
// Ports:
//   hb0_gtwiz_userclk_tx_usrclk2_int  TX user clock
//   hb0_gtwiz_reset_n_int             asynchronous active-low reset
//   sched_enable                      run request; dropping it finishes the frame
//   preamble_length/burst_length/burst_period  P, B, T (shadowed at launch)
//   payload_ready                     upstream FIFO has a word this cycle
//   tx_en, preamble_sel, payload_req  TX datapath controls
//   burst_start, burst_end            first / last tx cycle pulses of a frame
//   burst_count                       completed frames (wraps)
//   config_err, underrun_err          sticky error flags
module pon_burst_scheduler
  import pon_sched_pkg::*;
#(
  parameter int unsigned CNT_W  = CntWDefault,
  parameter int unsigned BCNT_W = BcntWDefault
) (
  input  logic              hb0_gtwiz_userclk_tx_usrclk2_int,
  input  logic              hb0_gtwiz_reset_n_int,
  input  logic              sched_enable,
  input  logic [CNT_W-1:0]  preamble_length,
  input  logic [CNT_W-1:0]  burst_length,
  input  logic [CNT_W-1:0]  burst_period,
  input  logic              payload_ready,
  output logic              tx_en,
  output logic              preamble_sel,
  output logic              payload_req,
  output logic              burst_start,
  output logic              burst_end,
  output logic [BCNT_W-1:0] burst_count,
  output logic              config_err,
  output logic              underrun_err
);

  localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
  localparam logic [CNT_W:0]    SumOne  = (CNT_W + 1)'(1);
  localparam logic [BCNT_W-1:0] BcntOne = BCNT_W'(1);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] p_sh, b_sh, t_sh, p_eff, b_eff;
  logic [CNT_W:0]   cnt_x, p_x, sum_x;
  logic             cfg_ok, launch, cfg_fail, frame_end, running, burst_end_d, en_q;

  pon_cfg_shadow #(
    .CNT_W (CNT_W)
  ) u_cfg_shadow (
    .clk    (hb0_gtwiz_userclk_tx_usrclk2_int),
    .rst_n  (hb0_gtwiz_reset_n_int),
    .load   (launch),
    .p_in   (preamble_length),
    .b_in   (burst_length),
    .t_in   (burst_period),
    .p      (p_sh),
    .b      (b_sh),
    .t      (t_sh),
    .cfg_ok (cfg_ok)
  );

  // Next-cycle state is decoded from the period counter position, so every
  // output can be registered from the decoded next state.
  always_comb begin
    launch    = 1'b0;
    cfg_fail  = 1'b0;
    frame_end = (state_q != StIdle) && (cnt_q == t_sh - CntOne);
    if ((state_q == StIdle) || frame_end) begin
      if (sched_enable && cfg_ok) begin
        launch = 1'b1;
      end else if (sched_enable) begin
        cfg_fail = 1'b1;
      end
    end
    running = launch || ((state_q != StIdle) && !frame_end);

    // On launch the shadows load this edge, so decode from the live inputs.
    p_eff = launch ? preamble_length : p_sh;
    b_eff = launch ? burst_length    : b_sh;

    if (launch || !running) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntOne;
    end

    cnt_x = {1'b0, cnt_d};
    p_x   = {1'b0, p_eff};
    sum_x = p_x + {1'b0, b_eff};

    state_d = StIdle;
    if (running) begin
      if (cnt_x < p_x) begin
        state_d = StPre;
      end else if (cnt_x < sum_x) begin
        state_d = StData;
      end else begin
        state_d = StGap;
      end
    end
    burst_end_d = running && (cnt_x == sum_x - SumOne);
  end

  always_ff @(posedge hb0_gtwiz_userclk_tx_usrclk2_int or negedge hb0_gtwiz_reset_n_int) begin
    if (!hb0_gtwiz_reset_n_int) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      en_q         <= 1'b0;
      tx_en        <= 1'b0;
      preamble_sel <= 1'b0;
      payload_req  <= 1'b0;
      burst_start  <= 1'b0;
      burst_end    <= 1'b0;
      burst_count  <= '0;
      config_err   <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      en_q         <= sched_enable;
      tx_en        <= is_tx(state_d);
      preamble_sel <= (state_d == StPre);
      payload_req  <= (state_d == StData);
      burst_start  <= launch;
      burst_end    <= burst_end_d;
      if (burst_end_d) begin
        burst_count <= burst_count + BcntOne;
      end
      // Falling edge of the run request clears a stale config error.
      if (en_q && !sched_enable) begin
        config_err <= 1'b0;
      end else if (cfg_fail) begin
        config_err <= 1'b1;
      end
      if (payload_req && !payload_ready) begin
        underrun_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pon_burst_scheduler.sv
// Self-checking bench for pon_burst_scheduler.
// A frame-level reference model builds the whole expected frame (T cycles of
// tx pattern) whenever a launch is due and pushes one expected output vector per
// cycle into a scoreboard; a separate monitor pops and compares on the falling edge.
module tb_pon_burst_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sched_enable = 1'b0;
  logic [31:0] pl = '0, bl = '0, bp = '0;
  logic        payload_ready = 1'b1;
  logic        tx_en, preamble_sel, payload_req, burst_start, burst_end;
  logic [31:0] burst_count;
  logic        config_err, underrun_err;

  typedef struct packed {
    logic        tx;
    logic        pre;
    logic        req;
    logic        start;
    logic        fin;
    logic        cfg;
    logic        und;
    logic [31:0] cnt;
  } obs_t;

  obs_t        sb[$];
  obs_t        plan[$];
  obs_t        cur = '0;
  logic        m_cfg = 1'b0, m_und = 1'b0, m_prev_en = 1'b0;
  logic [31:0] m_cnt = '0;
  int          n_checks = 0, n_fail = 0;

  pon_burst_scheduler #(
    .CNT_W  (32),
    .BCNT_W (32)
  ) dut (
    .hb0_gtwiz_userclk_tx_usrclk2_int (clk),
    .hb0_gtwiz_reset_n_int            (rst_n),
    .sched_enable                     (sched_enable),
    .preamble_length                  (pl),
    .burst_length                     (bl),
    .burst_period                     (bp),
    .payload_ready                    (payload_ready),
    .tx_en                            (tx_en),
    .preamble_sel                     (preamble_sel),
    .payload_req                      (payload_req),
    .burst_start                      (burst_start),
    .burst_end                        (burst_end),
    .burst_count                      (burst_count),
    .config_err                       (config_err),
    .underrun_err                     (underrun_err)
  );

  always #5 clk = ~clk;

  function automatic obs_t dut_obs();
    return {tx_en, preamble_sel, payload_req, burst_start, burst_end,
            config_err, underrun_err, burst_count};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  function automatic bit cfg_valid(logic [31:0] p, logic [31:0] b, logic [31:0] t);
    longint s;
    s = longint'({32'd0, p}) + longint'({32'd0, b});
    return (t != 0) && (s != 0) && (s <= longint'({32'd0, t}));
  endfunction

  // Whole frame laid out as T per-cycle entries.
  task automatic build_frame(int p, int b, int t);
    for (int i = 0; i < t; i++) begin
      obs_t e;
      e       = '0;
      e.pre   = (i < p);
      e.req   = (i >= p) && (i < p + b);
      e.tx    = e.pre || e.req;
      e.start = (i == 0);
      e.fin   = (i == p + b - 1);
      plan.push_back(e);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      plan.delete();
      sb.delete();
      cur       = '0;
      m_cfg     = 1'b0;
      m_und     = 1'b0;
      m_cnt     = '0;
      m_prev_en = 1'b0;
      return;
    end
    if (cur.req && !payload_ready) m_und = 1'b1;
    if (m_prev_en && !sched_enable) m_cfg = 1'b0;
    m_prev_en = sched_enable;
    if (plan.size() == 0 && sched_enable) begin
      if (cfg_valid(pl, bl, bp)) build_frame(int'(pl), int'(bl), int'(bp));
      else m_cfg = 1'b1;
    end
    if (plan.size() > 0) cur = plan.pop_front();
    else cur = '0;
    if (cur.fin) m_cnt = m_cnt + 1;
    cur.cfg = m_cfg;
    cur.und = m_und;
    cur.cnt = m_cnt;
    sb.push_back(cur);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && sb.size() > 0) begin
      obs_t e;
      e = sb.pop_front();
      check("cycle_outputs", 64'(dut_obs()), 64'(e));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check("async_reset", 64'(dut_obs()), 64'd0);
    sched_enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    check("reset_state", 64'(dut_obs()), 64'd0);

    // P=4 B=8 T=20, enable held
    pl = 4; bl = 8; bp = 20;
    sched_enable = 1'b1;
    step(1);
    check("s1_launch", {61'd0, burst_start, tx_en, preamble_sel}, 64'd7);
    step(60);
    check("s1_count60", 64'(burst_count), 64'd3);
    sched_enable = 1'b0;
    step(25);

    // P=0 B=5 T=5: continuous tx
    pl = 0; bl = 5; bp = 5;
    sched_enable = 1'b1;
    step(1);
    check("s2_start", {62'd0, burst_start, preamble_sel}, 64'd2);
    step(4);
    check("s2_end4", 64'(burst_end), 64'd1);
    step(15);
    sched_enable = 1'b0;
    step(10);

    // P+B>T: rejected, then fixed and restarted with zero gap
    pl = 6; bl = 6; bp = 10;
    sched_enable = 1'b1;
    step(5);
    check("s3_cfg_err", {62'd0, config_err, tx_en}, 64'd2);
    bp = 12;
    sched_enable = 1'b0;
    step(1);
    check("s3_cfg_clear", 64'(config_err), 64'd0);
    sched_enable = 1'b1;
    step(30);
    sched_enable = 1'b0;
    step(15);

    // B changed mid-DATA takes effect next frame
    pl = 4; bl = 8; bp = 20;
    sched_enable = 1'b1;
    step(7);
    bl = 2;
    step(40);
    sched_enable = 1'b0;
    step(25);

    // Graceful stop on the 3rd DATA cycle
    bl = 8;
    sched_enable = 1'b1;
    step(7);
    sched_enable = 1'b0;
    step(30);
    check("s5_stopped", {62'd0, tx_en, burst_start}, 64'd0);

    // Reset mid-DATA
    sched_enable = 1'b1;
    step(6);
    do_reset();

    // One-cycle underrun during DATA
    sched_enable = 1'b1;
    step(6);
    payload_ready = 1'b0;
    step(1);
    payload_ready = 1'b1;
    step(40);
    check("s6_underrun", 64'(underrun_err), 64'd1);
    sched_enable = 1'b0;
    step(25);

    // Randomized phase
    do_reset();
    pl = 3; bl = 4; bp = 10;
    sched_enable = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) sched_enable = ~sched_enable;
      if ($urandom_range(0, 29) == 0) begin
        pl = $urandom_range(0, 6);
        bl = $urandom_range(0, 8);
        bp = $urandom_range(0, 20);
      end
      payload_ready = ($urandom_range(0, 15) != 0);
      if (i % 500 == 499) do_reset();
      else step(1);
    end

    step(2);
    check("sb_drain", 64'(sb.size() <= 1), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
